// File: rtl/filter_sched_pkg.sv
// Shared definitions for the time-shared channel filter scheduler.
package filter_sched_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/filter_sched_core.sv
// Debounce decision: all-ones history sets the output, all-zeros clears it,
// any mixed history holds the previous output bit.
module filter_core
    import filter_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic [DEPTH-1:0] hist_i,
    input  logic             out_i,
    output logic             out_o
);

    // Output decision from the freshly shifted history
    always_comb begin
        out_o = out_i;
        if (&hist_i) begin
            out_o = 1'b1;
        end else if (~|hist_i) begin
            out_o = 1'b0;
        end else begin
            out_o = out_i;
        end
    end

endmodule

// File: rtl/filter_sched.sv
// Round-robin scheduler sharing one filter evaluation across N_CH channels,
// servicing at most one channel per clock edge.
module filter_sched
    import filter_sched_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] sig_out,
    output logic [CW-1:0]   cur_ch,
    output logic            upd
);

    state_e             state_q;
    logic [CW-1:0]      ptr_q;
    logic [CW-1:0]      cur_ch_q;
    logic               upd_q;
    logic [N_CH-1:0]    sig_out_q;
    logic [DEPTH-1:0]   hist_q [N_CH];

    logic               run_s;
    logic [CW-1:0]      grant_s;
    logic [CW-1:0]      idx_s;
    logic [DEPTH-1:0]   hist_d;
    logic               filt_s;

    assign run_s = en && (ch_en != '0);

    // Round-robin grant: the descending scan leaves the nearest enabled channel after ptr
    always_comb begin
        grant_s = ptr_q;
        idx_s   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx_s = CW'((int'(ptr_q) + k) % N_CH);
            if (ch_en[idx_s]) begin
                grant_s = idx_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // History of the granted channel after shifting in its current sample
    always_comb begin
        hist_d = {hist_q[grant_s][DEPTH-2:0], sig_in[grant_s]};
    end

    filter_core #(
        .DEPTH (DEPTH)
    ) u_filter_core (
        .hist_i (hist_d),
        .out_i  (sig_out_q[grant_s]),
        .out_o  (filt_s)
    );

    // Scheduler state machine with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= CW'(N_CH - 1);
            cur_ch_q  <= '0;
            upd_q     <= 1'b0;
            sig_out_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    upd_q <= 1'b0;
                    if (run_s) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (run_s) begin
                        hist_q[grant_s]    <= hist_d;
                        sig_out_q[grant_s] <= filt_s;
                        ptr_q              <= grant_s;
                        cur_ch_q           <= grant_s;
                        upd_q              <= 1'b1;
                    end else begin
                        upd_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    upd_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sig_out = sig_out_q;
    assign cur_ch  = cur_ch_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_filter_sched.sv
// Self-checking bench for filter_sched against a queue-based reference model.
module tb_filter_sched;

    localparam int NC = 4;
    localparam int DP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [NC-1:0] ch_en = '0;
    logic [NC-1:0] sig_in = '0;
    logic [NC-1:0] sig_out;
    logic [1:0]    cur_ch;
    logic          upd;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: last DP samples per channel, oldest first
    int            m_hist [NC][$];
    logic [NC-1:0] m_out;
    logic [1:0]    m_cur;
    logic          m_upd;
    int            m_ptr;
    bit            m_scan;

    filter_sched #(.N_CH(NC), .DEPTH(DP)) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .ch_en   (ch_en),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .cur_ch  (cur_ch),
        .upd     (upd)
    );

    always #5 clock = ~clock;

    task automatic model_edge(input logic r, input logic e, input logic [NC-1:0] ce,
                              input logic [NC-1:0] si);
        int g;
        int ones;
        if (r) begin
            for (int c = 0; c < NC; c++) begin
                m_hist[c].delete();
                for (int d = 0; d < DP; d++) m_hist[c].push_back(0);
            end
            m_out = '0; m_upd = 1'b0; m_cur = '0; m_ptr = NC - 1; m_scan = 0;
        end else if (!m_scan) begin
            m_upd = 1'b0;
            if (e && ce != '0) m_scan = 1;
        end else if (e && ce != '0) begin
            g = -1;
            for (int k = 1; k <= NC; k++) begin
                if (g < 0 && ce[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            end
            m_hist[g].push_back(int'(si[g]));
            void'(m_hist[g].pop_front());
            ones = 0;
            foreach (m_hist[g][j]) ones += m_hist[g][j];
            if (ones == DP) m_out[g] = 1'b1;
            else if (ones == 0) m_out[g] = 1'b0;
            m_ptr = g; m_cur = 2'(g); m_upd = 1'b1;
        end else begin
            m_upd = 1'b0; m_scan = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [NC-1:0] ce,
                        input logic [NC-1:0] si);
        reset = r; en = e; ch_en = ce; sig_in = si;
        @(posedge clock);
        model_edge(r, e, ce, si);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 4'($urandom), 4'($urandom));
            n_cmp++;
            if (sig_out !== 4'h0 || upd !== 1'b0 || cur_ch !== 2'd0) begin
                n_bad++;
                $display("FAIL reset: sig_out=%h upd=%b cur_ch=%0d required 0/0/0", sig_out, upd, cur_ch);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
            n_cmp++;
            if (upd !== 1'b0 || sig_out !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_en0: upd=%b sig_out=%h required 0/0", upd, sig_out);
            end
        end
    endtask

    task automatic test_round_robin();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int e = 1; e <= 20; e++) begin
            step(1'b0, 1'b1, 4'hF, 4'hF);
            n_cmp++;
            if (sig_out !== m_out || cur_ch !== m_cur || upd !== m_upd) begin
                n_bad++;
                $display("FAIL rr_model edge %0d: got %h/%0d/%b required %h/%0d/%b",
                         e, sig_out, cur_ch, upd, m_out, m_cur, m_upd);
            end
            if (e >= 2) begin
                n_cmp++;
                if (cur_ch !== 2'((e - 2) % 4) || upd !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rr_order edge %0d: cur_ch=%0d upd=%b required %0d/1",
                             e, cur_ch, upd, (e - 2) % 4);
                end
            end
            if (e == 13 || e == 14) begin
                n_cmp++;
                if (sig_out[0] !== (e == 14)) begin
                    n_bad++;
                    $display("FAIL rr_rise0 edge %0d: sig_out[0]=%b required %b", e, sig_out[0], e == 14);
                end
            end
            if (e == 16 || e == 17) begin
                n_cmp++;
                if ((sig_out === 4'hF) !== (e == 17)) begin
                    n_bad++;
                    $display("FAIL rr_full edge %0d: sig_out=%h required full=%b", e, sig_out, e == 17);
                end
            end
        end
    endtask

    task automatic test_masking();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int e = 1; e <= 14; e++) begin
            step(1'b0, 1'b1, 4'b0101, 4'($urandom) | 4'b1010);
            n_cmp++;
            if (sig_out !== m_out || cur_ch !== m_cur || upd !== m_upd) begin
                n_bad++;
                $display("FAIL mask_model edge %0d: got %h/%0d/%b required %h/%0d/%b",
                         e, sig_out, cur_ch, upd, m_out, m_cur, m_upd);
            end
            if (e >= 2) begin
                n_cmp++;
                if (cur_ch !== ((e % 2 == 0) ? 2'd0 : 2'd2) || sig_out[1] !== 1'b0 || sig_out[3] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mask_alt edge %0d: cur_ch=%0d sig_out=%h required ch %0d, bits1/3 zero",
                             e, cur_ch, sig_out, (e % 2 == 0) ? 0 : 2);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq;
        seq = 8'b1111_0111;
        step(1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b0001, 4'h0);
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b1, 4'b0001, {3'($urandom), seq[s]});
            n_cmp++;
            if (sig_out[0] !== (s == 7) || cur_ch !== 2'd0 || upd !== 1'b1) begin
                n_bad++;
                $display("FAIL glitch service %0d: sig_out[0]=%b cur_ch=%0d upd=%b required %b/0/1",
                         s + 1, sig_out[0], cur_ch, upd, s == 7);
            end
        end
    endtask

    task automatic test_idle();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'h0, 4'($urandom));
            n_cmp++;
            if (upd !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_noch: upd=%b required 0", upd);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0);
        n_cmp++;
        if (upd !== 1'b0 || cur_ch !== 2'd1) begin
            n_bad++;
            $display("FAIL idle_drop: upd=%b cur_ch=%0d required 0/1", upd, cur_ch);
        end
        step(1'b0, 1'b1, 4'hF, 4'h0);
        n_cmp++;
        if (upd !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_rearm: upd=%b required 0", upd);
        end
        step(1'b0, 1'b1, 4'hF, 4'h0);
        n_cmp++;
        if (upd !== 1'b1 || cur_ch !== 2'd2 || cur_ch !== m_cur) begin
            n_bad++;
            $display("FAIL idle_resume: upd=%b cur_ch=%0d required 1/2", upd, cur_ch);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 4'hF, 4'hF);
        n_cmp++;
        if (sig_out !== 4'hF) begin
            n_bad++;
            $display("FAIL midrst_pre: sig_out=%h required f", sig_out);
        end
        step(1'b1, 1'b1, 4'hF, 4'hF);
        n_cmp++;
        if (sig_out !== 4'h0 || upd !== 1'b0 || cur_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL midrst: sig_out=%h upd=%b cur_ch=%0d required 0/0/0", sig_out, upd, cur_ch);
        end
        step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        n_cmp++;
        if (upd !== 1'b1 || cur_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL midrst_first: upd=%b cur_ch=%0d required 1/0", upd, cur_ch);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] si;
        step(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 400; i++) begin
            si = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ((i / 8) % 2 == 0 ? 4'hF : 4'h0);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), 4'($urandom), si);
            n_cmp++;
            if (sig_out !== m_out || cur_ch !== m_cur || upd !== m_upd) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %h/%0d/%b required %h/%0d/%b",
                         i, sig_out, cur_ch, upd, m_out, m_cur, m_upd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_glitch();
        test_idle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_sched.md
FILTER_SCHED -- requirements
Module: filter_sched

Interface
REQ-001 Parameter N_CH, default 4: number of input channels time-sharing the filter datapath; legal values 2..8.
REQ-002 Parameter DEPTH, default 4: samples per channel history window; legal values 2..8.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 en  input  1  global run enable.
REQ-006 ch_en  input  N_CH  per-channel enable mask; bit i=1 makes channel i eligible for service.
REQ-007 sig_in  input  N_CH  raw per-channel input bits, sampled only when that channel is serviced.
REQ-008 sig_out  output  N_CH  registered filtered outputs, one bit per channel.
REQ-009 cur_ch  output  clog2(N_CH)  registered index of the channel serviced at the last edge where upd was set.
REQ-010 upd  output  1  registered one-cycle pulse; high for one cycle after each edge on which a channel was serviced.

Function
REQ-011 The block shall hold a DEPTH-bit history register per channel and time-share one filter evaluation among channels, servicing at most one channel per clock edge.
REQ-012 The state machine shall have two states, IDLE and SCAN; run = en && (ch_en != 0).
REQ-013 In IDLE: if run=1 at an edge, go to SCAN; no channel is serviced on that edge; upd=0.
REQ-014 In SCAN: if run=1 at an edge, service the granted channel and stay in SCAN; if run=0, service nothing, set upd=0 and go to IDLE.
REQ-015 Grant shall be round-robin: first channel i with ch_en[i]=1, searching from ptr+1 upward and wrapping modulo N_CH; ptr is the last serviced channel.
REQ-016 Servicing channel g on an edge shall do all of the following:
- shift sig_in[g] into the LSB of history[g];
- set ptr and cur_ch to g;
- set upd=1;
- update sig_out[g] from the new history: 1 if all DEPTH bits are 1, 0 if all are 0, otherwise unchanged.
REQ-017 The sig_out[g] update shall take effect on the same edge as the shift, with no added latency.
REQ-018 Unserviced channels, including disabled ones, shall keep their history and sig_out unchanged.
REQ-019 ch_en changes shall take effect in the grant computed for the next edge.
REQ-020 When only one channel is enabled, it shall be serviced on every SCAN edge.
REQ-021 When the enabled channel with the highest index is serviced, the next search shall wrap to index 0.

Reset
REQ-022 When reset=1 at an edge, the block shall clear:
- every history register to 0;
- sig_out to 0;
- upd to 0;
- cur_ch to 0.
REQ-023 On the same reset edge, state shall go to IDLE and ptr shall go to N_CH-1, so the first grant after reset is the lowest enabled index.
REQ-024 Reset shall take priority over all other activity, including a reset applied mid-scan.

Structure
REQ-025 A shared package shall hold the state encoding (IDLE, SCAN) and the default values of N_CH and DEPTH.
REQ-026 The all-ones / all-zeros / hold decision shall live in one sub-module, filter_core.
REQ-027 filter_core shall be combinational, take the new DEPTH-bit history and the current output bit, and be instantiated exactly once.

Verification
REQ-028 Reset: assert reset for 2 edges with arbitrary inputs -> sig_out=0, upd=0, cur_ch=0, and no upd while en=0.
REQ-029 Full round-robin: N_CH=4, DEPTH=4, ch_en=4'hF, sig_in=4'hF, en rises before edge 1. Required response:
- cur_ch runs 0,1,2,3,0,... starting at edge 2;
- sig_out[0] rises after edge 14;
- sig_out=4'hF after edge 17.
REQ-030 Masking: ch_en=4'b0101 -> cur_ch alternates 0,2,0,2; sig_out[1] and sig_out[3] never change.
REQ-031 Glitch rejection: ch_en=4'b0001, sig_in[0] sequence 1,1,1,0,1,1,1,1 on successive services -> sig_out[0] stays 0 until after the 8th service, then becomes 1.
REQ-032 Idle conditions: en=1 with ch_en=0 stays IDLE with upd=0; dropping en mid-scan gives upd=0 on the next edge, and resuming continues from ptr+1.
REQ-033 Reset mid-operation: with sig_out=4'hF, pulse reset for one edge -> all outputs 0 on that edge, and the first grant after restart is channel 0.
